in_channel_fifo: RTL and testbench

IN_CHANNEL_FIFO -- requirements
Module: in_channel_fifo

---
 rtl/in_channel_fifo.sv | 101 ++++++++++
 tb/tb_in_channel_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/in_channel_fifo.sv
// Input channel FIFO between a host writer and a core issuing "in" reads.
// Circular buffer of NIn words (any size, not only powers of two). Reads
// return one cycle after the request as an rd_ack or rd_empty pulse.
// Full and empty are both judged on the registered count, so a read and a
// write in the same cycle never see each other.
module in_channel_fifo #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn = 16,
  localparam int CW = $clog2(NIn + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [MemoryElementWidth-1:0] wr_data,
  output logic                          wr_ready,
  input  logic                          rd_req,
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic                          rd_ack,
  output logic                          rd_empty,
  output logic [CW-1:0]                 in_size,
  output logic                          overflow
);

  localparam int PW = $clog2(NIn);

  logic [MemoryElementWidth-1:0] r_mem [NIn];
  logic [PW-1:0]                 r_wp;
  logic [PW-1:0]                 r_rp;
  logic [CW-1:0]                 r_cnt;
  logic [MemoryElementWidth-1:0] r_rd_data;
  logic                          r_rd_ack;
  logic                          r_rd_empty;
  logic                          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [PW-1:0] w_wp_next;
  logic [PW-1:0] w_rp_next;

  // Accept/decline decisions come only from the registered count.
  always_comb begin
    w_full    = (r_cnt == CW'(NIn));
    w_empty   = (r_cnt == '0);
    w_wr_acc  = wr_valid && !w_full;
    w_rd_acc  = rd_req && !w_empty;
    // Explicit compare keeps wrap correct for non-power-of-two depths.
    w_wp_next = (r_wp == PW'(NIn - 1)) ? '0 : r_wp + 1'b1;
    w_rp_next = (r_rp == PW'(NIn - 1)) ? '0 : r_rp + 1'b1;
  end

  // Storage array; not reset, stale words are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wp] <= wr_data;
    end
  end

  // Pointers, count, read response pulses and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_ack   <= 1'b0;
      r_rd_empty <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wp <= w_wp_next;
      end
      if (w_rd_acc) begin
        r_rp      <= w_rp_next;
        r_rd_data <= r_mem[r_rp];
      end
      r_rd_ack   <= w_rd_acc;
      r_rd_empty <= rd_req && w_empty;
      if (wr_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Outputs straight from registers; wr_ready decoded from the count.
  always_comb begin
    wr_ready = !w_full;
    rd_data  = r_rd_data;
    rd_ack   = r_rd_ack;
    rd_empty = r_rd_empty;
    in_size  = r_cnt;
    overflow = r_overflow;
  end

endmodule

// File: tb/tb_in_channel_fifo.sv
// Bench for in_channel_fifo at NIn=4, 12-bit words. Accepted pushes go to a
// scoreboard queue; every rd_ack pops the queue and compares the word.
module tb_in_channel_fifo;

  localparam int W  = 12;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    bit          wv;
    bit          rr;
    logic [W-1:0] d;
  } step_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready;
  logic          rd_req = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_ack;
  logic          rd_empty;
  logic [CW-1:0] in_size;
  logic          overflow;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb [$];
  int           m_cnt = 0;
  bit           m_ovf = 0;
  logic [W-1:0] m_last = '0;
  bit           exp_ack;
  bit           exp_empty;
  logic [W-1:0] exp_word;

  in_channel_fifo #(.MemoryElementWidth(W), .NIn(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_ack   (rd_ack),
    .rd_empty (rd_empty),
    .in_size  (in_size),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  // One clock of stimulus; updates the reference model from pre-edge state.
  task automatic cycle(input bit wv, input logic [W-1:0] wd, input bit rr);
    bit full;
    bit acc_w;
    full      = (m_cnt == N);
    acc_w     = wv && !full;
    exp_ack   = rr && (m_cnt != 0);
    exp_empty = rr && (m_cnt == 0);
    if (acc_w) sb.push_back(wd);
    if (wv && full) m_ovf = 1;
    m_cnt = m_cnt + (acc_w ? 1 : 0) - (exp_ack ? 1 : 0);
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (in_size !== CW'(0)) begin errors++; $display("FAIL reset_in_size got %0d want 0", in_size); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_ack !== 1'b0 || rd_empty !== 1'b0) begin errors++; $display("FAIL reset_pulses got ack=%b empty=%b want 0 0", rd_ack, rd_empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
  endtask

  task automatic test_basic();
    step_t s [5] = '{'{1, 0, 12'd88}, '{1, 0, 12'd44}, '{0, 1, 12'd0}, '{0, 1, 12'd0}, '{0, 1, 12'd0}};
    for (int i = 0; i < 5; i++) begin
      cycle(s[i].wv, s[i].d, s[i].rr);
      checks++; if (in_size !== CW'(m_cnt)) begin errors++; $display("FAIL basic_in_size step %0d got %0d want %0d", i, in_size, m_cnt); end
      checks++; if (rd_ack !== exp_ack || rd_empty !== exp_empty) begin errors++; $display("FAIL basic_pulses step %0d got ack=%b empty=%b want %b %b", i, rd_ack, rd_empty, exp_ack, exp_empty); end
      if (exp_ack) m_last = sb.pop_front();
      if (s[i].rr) begin
        checks++; if (rd_data !== m_last) begin errors++; $display("FAIL basic_rd_data step %0d got %0d want %0d", i, rd_data, m_last); end
      end
    end
    checks++; if (rd_data !== 12'd44) begin errors++; $display("FAIL basic_hold got %0d want 44", rd_data); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        cycle(1, W'(10 + 3 * r + k), 0);
        checks++; if (in_size !== CW'(m_cnt)) begin errors++; $display("FAIL wrap_push_size got %0d want %0d", in_size, m_cnt); end
      end
      for (int k = 0; k < 3; k++) begin
        cycle(0, '0, 1);
        checks++; if (rd_ack !== exp_ack) begin errors++; $display("FAIL wrap_ack got %b want %b", rd_ack, exp_ack); end
        if (exp_ack) m_last = sb.pop_front();
        checks++; if (rd_data !== W'(10 + 3 * r + k)) begin errors++; $display("FAIL wrap_order got %0d want %0d", rd_data, 10 + 3 * r + k); end
      end
    end
    checks++; if (in_size !== CW'(0)) begin errors++; $display("FAIL wrap_end_size got %0d want 0", in_size); end
  endtask

  task automatic test_simultaneous();
    step_t s [5] = '{'{1, 1, 12'd7}, '{1, 0, 12'd20}, '{1, 0, 12'd21}, '{1, 0, 12'd22}, '{1, 1, 12'd9}};
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf_before got %b want 0", overflow); end
    for (int i = 0; i < 5; i++) begin
      cycle(s[i].wv, s[i].d, s[i].rr);
      checks++; if (in_size !== CW'(m_cnt)) begin errors++; $display("FAIL simul_in_size step %0d got %0d want %0d", i, in_size, m_cnt); end
      checks++; if (rd_ack !== exp_ack || rd_empty !== exp_empty) begin errors++; $display("FAIL simul_pulses step %0d got ack=%b empty=%b want %b %b", i, rd_ack, rd_empty, exp_ack, exp_empty); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL simul_overflow step %0d got %b want %b", i, overflow, m_ovf); end
      if (exp_ack) begin
        m_last = sb.pop_front();
        checks++; if (rd_data !== m_last) begin errors++; $display("FAIL simul_rd_data step %0d got %0d want %0d", i, rd_data, m_last); end
      end
    end
    checks++; if (rd_data !== 12'd7 || in_size !== CW'(3) || overflow !== 1'b1) begin errors++; $display("FAIL simul_final got data=%0d size=%0d ovf=%b want 7 3 1", rd_data, in_size, overflow); end
  endtask

  task automatic test_full();
    step_t s [12] = '{'{0, 1, 12'd0}, '{0, 1, 12'd0}, '{0, 1, 12'd0},
                      '{1, 0, 12'd1}, '{1, 0, 12'd2}, '{1, 0, 12'd3}, '{1, 0, 12'd4}, '{1, 0, 12'd5},
                      '{0, 1, 12'd0}, '{0, 1, 12'd0}, '{0, 1, 12'd0}, '{0, 1, 12'd0}};
    for (int i = 0; i < 12; i++) begin
      cycle(s[i].wv, s[i].d, s[i].rr);
      checks++; if (in_size !== CW'(m_cnt)) begin errors++; $display("FAIL full_in_size step %0d got %0d want %0d", i, in_size, m_cnt); end
      checks++; if (wr_ready !== (m_cnt != N)) begin errors++; $display("FAIL full_wr_ready step %0d got %b want %b", i, wr_ready, m_cnt != N); end
      checks++; if (rd_ack !== exp_ack || rd_empty !== exp_empty) begin errors++; $display("FAIL full_pulses step %0d got ack=%b empty=%b want %b %b", i, rd_ack, rd_empty, exp_ack, exp_empty); end
      if (exp_ack) begin
        m_last = sb.pop_front();
        checks++; if (rd_data !== m_last) begin errors++; $display("FAIL full_rd_data step %0d got %0d want %0d", i, rd_data, m_last); end
      end
    end
    checks++; if (rd_data !== 12'd4 || overflow !== 1'b1) begin errors++; $display("FAIL full_final got data=%0d ovf=%b want 4 1", rd_data, overflow); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) cycle(1, W'(30 + k), 0);
    checks++; if (in_size !== CW'(3)) begin errors++; $display("FAIL rstmid_pre_size got %0d want 3", in_size); end
    reset    = 1'b1;
    rd_req   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 12'd99;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    sb.delete();
    m_cnt  = 0;
    m_ovf  = 0;
    m_last = '0;
    checks++; if (in_size !== CW'(0)) begin errors++; $display("FAIL rstmid_in_size got %0d want 0", in_size); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_ack !== 1'b0 || rd_empty !== 1'b0) begin errors++; $display("FAIL rstmid_pulses got ack=%b empty=%b want 0 0", rd_ack, rd_empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    cycle(1, 12'd5, 0);
    checks++; if (in_size !== CW'(1)) begin errors++; $display("FAIL rstmid_push_size got %0d want 1", in_size); end
    cycle(0, '0, 1);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %b want 1", rd_ack); end
    if (exp_ack) exp_word = sb.pop_front();
    else exp_word = 12'd5;
    checks++; if (rd_data !== exp_word) begin errors++; $display("FAIL rstmid_rd_data got %0d want %0d", rd_data, exp_word); end
    checks++; if (in_size !== CW'(0)) begin errors++; $display("FAIL rstmid_end_size got %0d want 0", in_size); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_simultaneous();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
